// File: rtl/kmap_chk_pkg.sv
// Shared types and defaults for the k-map response checker.
package kmap_chk_pkg;

    localparam int unsigned N_VARS_DEF        = 4;
    localparam int unsigned N_VECTORS         = 2**N_VARS_DEF;
    localparam int unsigned SETTLE_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/kmap_settle_timer.sv
// Settle counter: cleared on DRIVE entry, pulses tc_c on the last settle cycle.
module kmap_settle_timer
    import kmap_chk_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc_c
);

    localparam int unsigned    CW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]  LAST = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] count;

    // Counter parks at LAST until the next clear, so it never wraps.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !tc_c) begin
            count <= count + CW'(1);
        end
    end

    assign tc_c = enable && (count == LAST);

endmodule

// File: rtl/kmap_response_checker.sv
// Exhaustive truth-table exerciser for a 4-input combinational block.
// Optional build macro KMAP_CHK_STOP_ON_FAIL_EN ends the run at the first mismatch.
module kmap_response_checker
    import kmap_chk_pkg::*;
#(
    parameter int unsigned           N_VARS        = N_VARS_DEF,
    parameter int unsigned           SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter logic [2**N_VARS-1:0]  EXPECTED      = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  f_in,
    output logic [N_VARS-1:0]     vec_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [2**N_VARS-1:0]  captured,
    output logic [N_VARS:0]       mismatch_count,
    output logic [N_VARS-1:0]     first_fail_idx,
    output logic                  first_fail_valid
);

    localparam int unsigned          CNT_W    = N_VARS + 1;
    localparam logic [N_VARS-1:0]    LAST_IDX = N_VARS'(2**N_VARS - 1);

    state_t                 state_q;
    state_t                 state_d;
    logic [N_VARS-1:0]      idx_d;
    logic [2**N_VARS-1:0]   cap_d;
    logic [N_VARS:0]        mm_d;
    logic [N_VARS-1:0]      ffi_d;
    logic                   ffv_d;
    logic                   timer_clear_c;
    logic                   settle_done_c;
    logic                   miss_c;

    kmap_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear_c),
        .enable (state_q == DRIVE),
        .tc_c   (settle_done_c)
    );

    // Next-state, capture and compare logic; vec_out doubles as the vector index.
    always_comb begin
        state_d       = state_q;
        idx_d         = vec_out;
        cap_d         = captured;
        mm_d          = mismatch_count;
        ffi_d         = first_fail_idx;
        ffv_d         = first_fail_valid;
        timer_clear_c = 1'b0;
        miss_c        = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d       = DRIVE;
                    idx_d         = '0;
                    cap_d         = '0;
                    mm_d          = '0;
                    ffi_d         = '0;
                    ffv_d         = 1'b0;
                    timer_clear_c = 1'b1;
                end
            end
            DRIVE: begin
                if (settle_done_c) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                cap_d[vec_out] = f_in;
                miss_c         = (f_in != EXPECTED[vec_out]);
                if (miss_c) begin
                    mm_d = mismatch_count + CNT_W'(1);
                    if (!first_fail_valid) begin
                        ffi_d = vec_out;
                        ffv_d = 1'b1;
                    end
                end
                if (vec_out == LAST_IDX) begin
                    state_d = DONE;
                end
`ifdef KMAP_CHK_STOP_ON_FAIL_EN
                else if (miss_c && !first_fail_valid) begin
                    state_d = DONE;
                end
`endif
                else begin
                    idx_d         = vec_out + N_VARS'(1);
                    state_d       = DRIVE;
                    timer_clear_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; status flags follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            vec_out          <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            captured         <= '0;
            mismatch_count   <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            state_q          <= state_d;
            vec_out          <= idx_d;
            busy             <= (state_d == DRIVE) || (state_d == SAMPLE);
            done             <= (state_d == DONE);
            pass             <= (state_d == DONE) && (mm_d == '0);
            captured         <= cap_d;
            mismatch_count   <= mm_d;
            first_fail_idx   <= ffi_d;
            first_fail_valid <= ffv_d;
        end
    end

endmodule

// File: tb/tb_kmap_response_checker.sv
// Bench for kmap_response_checker: run-level reference model checked every cycle.
module tb_kmap_response_checker;

    localparam int unsigned S    = 4;
    localparam int unsigned NVEC = 16;
    localparam logic [15:0] E    = 16'hA5F0;
`ifdef KMAP_CHK_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        f_in;
    logic [3:0]  vec_out;
    logic        busy, done, pass;
    logic [15:0] captured;
    logic [4:0]  mismatch_count;
    logic [3:0]  first_fail_idx;
    logic        first_fail_valid;

    logic [15:0] fn_table = 16'h0000;
    bit          chk_en = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    assign f_in = fn_table[vec_out];

    always #5 clk = ~clk;

    kmap_response_checker #(
        .N_VARS        (4),
        .SETTLE_CYCLES (S),
        .EXPECTED      (E)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .f_in             (f_in),
        .vec_out          (vec_out),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .captured         (captured),
        .mismatch_count   (mismatch_count),
        .first_fail_idx   (first_fail_idx),
        .first_fail_valid (first_fail_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail < 40)
                $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole-run length in cycles from the start edge to the first DONE cycle.
    function automatic int run_len(input logic [15:0] tab);
        int n = NVEC;
        bit found = 1'b0;
        for (int i = 0; i < NVEC; i++) begin
            if (STOP && !found && tab[i] != E[i]) begin
                n = i + 1;
                found = 1'b1;
            end
        end
        return n * (S + 1) + 1;
    endfunction

    // Results after the first k vectors have been sampled.
    function automatic void model_results(input logic [15:0] tab, input int k,
                                          output logic [15:0] cap, output logic [4:0] mm,
                                          output logic [3:0] ffi, output logic ffv);
        cap = '0; mm = '0; ffi = '0; ffv = 1'b0;
        for (int i = 0; i < k; i++) begin
            cap[i] = tab[i];
            if (tab[i] != E[i]) begin
                mm = mm + 5'd1;
                if (!ffv) begin
                    ffi = 4'(i);
                    ffv = 1'b1;
                end
            end
        end
    endfunction

    // Run-level model: elapsed cycles since start determine everything.
    bit          m_run = 1'b0;
    bit          m_done = 1'b0;
    int          m_t = 0;
    int          m_len = 0;
    int          m_k = 0;
    logic [3:0]  m_vec = '0;
    logic [15:0] m_tab = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_run = 1'b0; m_done = 1'b0; m_t = 0; m_k = 0; m_vec = '0;
        end else if (!m_run && start) begin
            m_run = 1'b1; m_done = 1'b0; m_t = 1; m_k = 0; m_vec = '0;
            m_tab = fn_table;
            m_len = run_len(fn_table);
        end else if (m_run) begin
            m_t = m_t + 1;
            m_k = (m_t - 1) / (S + 1);
            if (m_t == m_len) begin
                m_run = 1'b0;
                m_done = 1'b1;
            end else begin
                m_vec = 4'(m_k);
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic [15:0] c;
        logic [4:0]  mm;
        logic [3:0]  ffi;
        logic        ffv;
        if (chk_en) begin
            model_results(m_tab, m_k, c, mm, ffi, ffv);
            check("busy", busy, m_run);
            check("done", done, m_done);
            check("vec_out", vec_out, m_vec);
            check("captured", captured, c);
            check("mismatch_count", mismatch_count, mm);
            check("first_fail_idx", first_fail_idx, ffi);
            check("first_fail_valid", first_fail_valid, ffv);
            check("pass", pass, m_done && (mm == 5'd0));
        end
    end

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("done_timeout", done, 1'b1);
    endtask

    task automatic start_run(input logic [15:0] tab, input bit hold, output int cyc);
        fn_table = tab;
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        wait_done(cyc);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int cyc;
        logic [15:0] t;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_captured", captured, 16'h0000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);

        // Matching DUT: full run, pass.
        start_run(E, 1'b0, cyc);
        check("s1_latency", cyc, 81);
        check("s1_captured", captured, 16'hA5F0);
        check("s1_mm", mismatch_count, 0);
        check("s1_pass", pass, 1'b1);
        check("s1_ffv", first_fail_valid, 1'b0);

        // Single faulty minterm at index 6.
        start_run(16'hA5B0, 1'b0, cyc);
        check("s2_latency", cyc, STOP ? 36 : 81);
        check("s2_captured", captured, STOP ? 16'h0030 : 16'hA5B0);
        check("s2_mm", mismatch_count, 1);
        check("s2_ffi", first_fail_idx, 6);
        check("s2_ffv", first_fail_valid, 1'b1);
        check("s2_pass", pass, 1'b0);

        // Every vector wrong.
        start_run(~E, 1'b0, cyc);
        check("s3_latency", cyc, STOP ? 6 : 81);
        check("s3_mm", mismatch_count, STOP ? 1 : 16);
        check("s3_ffi", first_fail_idx, 0);
        check("s3_captured", captured, STOP ? 16'h0001 : 16'h5A0F);

        // Output stuck at 0.
        start_run(16'h0000, 1'b0, cyc);
        check("s3b_latency", cyc, STOP ? 26 : 81);
        check("s3b_mm", mismatch_count, STOP ? 1 : 8);
        check("s3b_ffi", first_fail_idx, 4);
        check("s3b_captured", captured, 16'h0000);

        // Reset mid-run at cycle 40, then a clean run.
        fn_table = E;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        check("s4_busy_before", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("s4_busy", busy, 1'b0);
        check("s4_vec", vec_out, 0);
        check("s4_captured", captured, 16'h0000);
        check("s4_mm", mismatch_count, 0);
        start_run(E, 1'b0, cyc);
        check("s4_latency", cyc, 81);
        check("s4_pass", pass, 1'b1);
        check("s4_result", captured, 16'hA5F0);

        // start held through the run: restart only from DONE.
        start_run(E, 1'b1, cyc);
        check("s5_latency", cyc, 81);
        @(negedge clk);
        start = 1'b0;
        check("s5_done_drop", done, 1'b0);
        check("s5_busy", busy, 1'b1);
        check("s5_captured_clr", captured, 16'h0000);
        wait_done(cyc);
        check("s5_latency2", cyc, 81);
        check("s5_result", captured, 16'hA5F0);

        // Random truth tables, some one bit away from expected.
        for (int r = 0; r < 8; r++) begin
            if (r % 2 == 0) t = 16'($urandom);
            else            t = E ^ (16'(1) << $urandom_range(0, 15));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_run(t, 1'b0, cyc);
            check("rand_latency", cyc, run_len(t));
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
